// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared bus definitions for the four-master round-robin bus arbiter.
// Holds the owner index type, the master indices and the active-low level constants.
package yutorina_bus_arbiter_pkg;

    localparam int ARB_MASTERS = 4;

    typedef logic [1:0] ArbOwnerBus;

    localparam ArbOwnerBus ARB_OWNER_IF   = 2'd0;
    localparam ArbOwnerBus ARB_OWNER_MEM  = 2'd1;
    localparam ArbOwnerBus ARB_OWNER_EXTA = 2'd2;
    localparam ArbOwnerBus ARB_OWNER_EXTB = 2'd3;

    // Active-low request/grant levels
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Active-low one-hot grant vector for a given owner
    function automatic logic [ARB_MASTERS-1:0] arb_grnt_decode(input ArbOwnerBus owner);
        logic [ARB_MASTERS-1:0] g;
        g        = {ARB_MASTERS{DISABLE_}};
        g[owner] = ENABLE_;
        return g;
    endfunction

endpackage

// File: rtl/yutorina_bus_arbiter_if.sv
// Arbiter bus bundle: per-master active-low requests in, active-low grants,
// owner index and timeout pulse out. The arbiter uses the slave modport.
interface yutorina_bus_arbiter_if;
    import yutorina_bus_arbiter_pkg::*;

    logic [ARB_MASTERS-1:0] m_req_;
    logic [ARB_MASTERS-1:0] m_grnt_;
    ArbOwnerBus             owner;
    logic                   timeout;

    modport master (output m_req_, input m_grnt_, input owner, input timeout);
    modport slave  (input m_req_, output m_grnt_, output owner, output timeout);

endinterface

// File: rtl/yutorina_arb_rr_sel.sv
// Round-robin next-owner selector: searches owner+1, owner+2, owner+3 (mod 4)
// for the first active-low request. found_o is low when no other master
// requests, in which case next_owner_o just echoes the current owner.
module yutorina_arb_rr_sel
    import yutorina_bus_arbiter_pkg::*;
(
    input  ArbOwnerBus             owner_i,
    input  logic [ARB_MASTERS-1:0] m_req_i,
    output ArbOwnerBus             next_owner_o,
    output logic                   found_o
);

    // Scan from the farthest offset down so the nearest requester wins last
    always_comb begin
        next_owner_o = owner_i;
        found_o      = 1'b0;
        for (int k = ARB_MASTERS - 1; k >= 1; k--) begin
            if (m_req_i[owner_i + ArbOwnerBus'(k)] == ENABLE_) begin
                next_owner_o = owner_i + ArbOwnerBus'(k);
                found_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Four-master round-robin bus arbiter with bus parking.
// Optional hold-limit feature: define YUTORINA_ARB_TIMEOUT_EN to build the
// hold counter that forcibly rotates ownership after MAX_HOLD contended cycles.
module yutorina_bus_arbiter
    import yutorina_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    yutorina_bus_arbiter_if.slave bus
);

    // The hold counter must be able to represent MAX_HOLD
    if ((1 << HOLD_W) <= MAX_HOLD) begin : g_bad_hold_w
        $error("HOLD_W too narrow for MAX_HOLD");
    end

    ArbOwnerBus             owner_q, owner_d;
    logic [ARB_MASTERS-1:0] grnt_q, grnt_d;
    ArbOwnerBus             rr_next;
    logic                   rr_found;
    logic                   own_req;

    yutorina_arb_rr_sel u_rr_sel (
        .owner_i      (owner_q),
        .m_req_i      (bus.m_req_),
        .next_owner_o (rr_next),
        .found_o      (rr_found)
    );

    assign own_req = (bus.m_req_[owner_q] == ENABLE_);

`ifdef YUTORINA_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic              expire;

    // Owner is revoked only when it has used up its contended hold budget
    assign expire = own_req && rr_found && (hold_q == HOLD_LIMIT);

    // Next owner, hold count and timeout pulse
    always_comb begin
        owner_d   = owner_q;
        hold_d    = hold_q;
        timeout_d = expire;
        if ((!own_req || expire) && rr_found) begin
            owner_d = rr_next;
            hold_d  = '0;
        end else if (own_req && rr_found && hold_q != HOLD_LIMIT) begin
            hold_d = hold_q + 1'b1;
        end
        grnt_d = arb_grnt_decode(owner_d);
    end

    // Hold counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    // Owner keeps the bus while requesting; otherwise hand over or park
    always_comb begin
        owner_d = owner_q;
        if (!own_req && rr_found) begin
            owner_d = rr_next;
        end
        grnt_d = arb_grnt_decode(owner_d);
    end

    assign bus.timeout = 1'b0;
`endif

    // Ownership and grant registers; reset parks the bus on the IF stage
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= ARB_OWNER_IF;
            grnt_q  <= arb_grnt_decode(ARB_OWNER_IF);
        end else begin
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
        end
    end

    assign bus.owner   = owner_q;
    assign bus.m_grnt_ = grnt_q;

endmodule
